multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32-style control unit: IF/ID/EX/MEM/WB/HALT sequencer with
// combinational control decode and a retired-instruction counter.
module multi_cycle_control #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned HALT_ID  = 10,
    parameter bit          MEM_WAIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] x17,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            mem_read,
    output logic            mem_write,
    output logic            i_or_d,
    output logic            ir_write,
    output logic            reg_write,
    output logic            pc_write,
    output logic            is_halted,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      mem_to_reg,
    output logic [1:0]      pc_source,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic            retire_c;
    logic            mem_rdy_c;

    // With MEM_WAIT cleared every memory access completes in one cycle.
    assign mem_rdy_c = MEM_WAIT ? mem_ready : 1'b1;

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        retire_c   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        is_halted  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        mem_to_reg = 2'd0;
        pc_source  = 2'd0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_rdy_c;
                if (mem_rdy_c) state_d = S_ID;
            end
            S_ID: begin
                alu_src_b = 2'd2;
                if (opcode == OP_ECALL) begin
                    if (x17 == XLEN'(HALT_ID)) begin
                        state_d = S_HALT;
                    end else begin
                        pc_write = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_ARITH: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'd1;
                        pc_write  = 1'b1;
                        pc_source = branch_taken ? 2'd1 : 2'd0;
                        retire_c  = 1'b1;
                        state_d   = S_IF;
                    end
                    OP_JAL: begin
                        pc_source = 2'd1;
                        state_d   = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        pc_source = 2'd2;
                        state_d   = S_WB;
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (mem_rdy_c) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire_c = (opcode == OP_STORE);
                        state_d  = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_IF;
                case (opcode)
                    OP_LOAD: mem_to_reg = 2'd1;
                    OP_JAL: begin
                        mem_to_reg = 2'd2;
                        pc_source  = 2'd1;
                    end
                    OP_JALR: begin
                        mem_to_reg = 2'd2;
                        pc_source  = 2'd2;
                    end
                    default: mem_to_reg = 2'd0;
                endcase
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    assign instret_d = retire_c ? instret_q + XLEN'(1) : instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed scoreboard bench for multi_cycle_control: default, XLEN=4 and
// MEM_WAIT=0 instances run one after another while the others sit in reset.
module tb_multi_cycle_control;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] c;
        logic [31:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_m, rst_4, rst_nw;
    logic [6:0]  opcode;
    logic        mem_ready, branch_taken;
    logic [31:0] x17;
    logic [3:0]  x17_4;

    logic        mrd[3], mwr[3], iod[3], irw[3], rgw[3], pcw[3], hlt[3], asa[3];
    logic [1:0]  asb[3], aop[3], m2r[3], pcs[3];
    logic [2:0]  st[3];
    logic [31:0] ir_m, ir_nw;
    logic [3:0]  ir_4;

    int   checks   = 0;
    int   failures = 0;
    int   sel      = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multi_cycle_control u_main (
        .clk(clk), .reset(rst_m), .opcode(opcode), .x17(x17),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_read(mrd[0]), .mem_write(mwr[0]), .i_or_d(iod[0]), .ir_write(irw[0]),
        .reg_write(rgw[0]), .pc_write(pcw[0]), .is_halted(hlt[0]), .alu_src_a(asa[0]),
        .alu_src_b(asb[0]), .alu_op(aop[0]), .mem_to_reg(m2r[0]), .pc_source(pcs[0]),
        .state(st[0]), .instret(ir_m)
    );

    multi_cycle_control #(.XLEN(4)) u_x4 (
        .clk(clk), .reset(rst_4), .opcode(opcode), .x17(x17_4),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_read(mrd[1]), .mem_write(mwr[1]), .i_or_d(iod[1]), .ir_write(irw[1]),
        .reg_write(rgw[1]), .pc_write(pcw[1]), .is_halted(hlt[1]), .alu_src_a(asa[1]),
        .alu_src_b(asb[1]), .alu_op(aop[1]), .mem_to_reg(m2r[1]), .pc_source(pcs[1]),
        .state(st[1]), .instret(ir_4)
    );

    multi_cycle_control #(.MEM_WAIT(1'b0)) u_nw (
        .clk(clk), .reset(rst_nw), .opcode(opcode), .x17(x17),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_read(mrd[2]), .mem_write(mwr[2]), .i_or_d(iod[2]), .ir_write(irw[2]),
        .reg_write(rgw[2]), .pc_write(pcw[2]), .is_halted(hlt[2]), .alu_src_a(asa[2]),
        .alu_src_b(asb[2]), .alu_op(aop[2]), .mem_to_reg(m2r[2]), .pc_source(pcs[2]),
        .state(st[2]), .instret(ir_nw)
    );

    // Control vector: {mr,mw,iod,irw,rw,pcw,hlt,sa,sb[2],op[2],m2r[2],ps[2]}
    function automatic logic [15:0] mk(input int mr, input int mw, input int io,
                                       input int iw, input int rw, input int pw,
                                       input int h, input int sa, input int sb,
                                       input int op, input int mt, input int ps);
        return {1'(mr), 1'(mw), 1'(io), 1'(iw), 1'(rw), 1'(pw), 1'(h), 1'(sa),
                2'(sb), 2'(op), 2'(mt), 2'(ps)};
    endfunction

    function automatic logic [15:0] c_if(input int rdy);
        return mk(1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] c_id();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    endfunction
    function automatic logic [15:0] c_ex(input int sa, input int sb, input int op,
                                         input int pw, input int ps);
        return mk(0, 0, 0, 0, 0, pw, 0, sa, sb, op, 0, ps);
    endfunction
    function automatic logic [15:0] c_mem(input int rd, input int wr, input int pw);
        return mk(rd, wr, 1, 0, 0, pw, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] c_wb(input int mt, input int ps);
        return mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, mt, ps);
    endfunction

    // Push the expectation for this cycle, then pop and compare at the falling edge.
    task automatic cyc(input string tag, input int es, input logic [15:0] ec, input int ei);
        exp_t        e;
        logic [15:0] oc;
        logic [31:0] oi;
        e.tag = tag; e.st = 3'(es); e.c = ec; e.ir = 32'(ei);
        sb_q.push_back(e);
        @(negedge clk);
        e  = sb_q.pop_front();
        oc = {mrd[sel], mwr[sel], iod[sel], irw[sel], rgw[sel], pcw[sel], hlt[sel],
              asa[sel], asb[sel], aop[sel], m2r[sel], pcs[sel]};
        oi = (sel == 1) ? 32'(ir_4) : ((sel == 2) ? ir_nw : ir_m);
        checks++;
        assert (st[sel] === e.st) else begin
            failures++;
            $error("FAIL %s state obs=%0d exp=%0d", e.tag, st[sel], e.st);
        end
        checks++;
        assert (oc === e.c) else begin
            failures++;
            $error("FAIL %s ctrl obs=%b exp=%b", e.tag, oc, e.c);
        end
        checks++;
        assert (oi === e.ir) else begin
            failures++;
            $error("FAIL %s instret obs=%0d exp=%0d", e.tag, oi, e.ir);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_m = 1'b0; rst_4 = 1'b0; rst_nw = 1'b0;
        opcode = OP_ARITH; mem_ready = 1'b1; branch_taken = 1'b0;
        x17 = 32'd0; x17_4 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, c_if(1), 0);
        rst_m = 1'b1;

        cyc("ar_if", 0, c_if(1), 0);
        cyc("ar_id", 1, c_id(), 0);
        cyc("ar_ex", 2, c_ex(1, 0, 2, 0, 0), 0);
        cyc("ar_wb", 4, c_wb(0, 0), 0);

        opcode = OP_LOAD;
        cyc("ld_if", 0, c_if(1), 1);
        cyc("ld_id", 1, c_id(), 1);
        cyc("ld_ex", 2, c_ex(1, 2, 0, 0, 0), 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_memwait", 3, c_mem(1, 0, 0), 1);
        mem_ready = 1'b1;
        cyc("ld_mem", 3, c_mem(1, 0, 0), 1);
        cyc("ld_wb", 4, c_wb(1, 0), 1);

        opcode = OP_STORE;
        cyc("st_if", 0, c_if(1), 2);
        cyc("st_id", 1, c_id(), 2);
        cyc("st_ex", 2, c_ex(1, 2, 0, 0, 0), 2);
        cyc("st_mem", 3, c_mem(0, 1, 1), 2);

        opcode = OP_BRANCH; branch_taken = 1'b1;
        cyc("bt_if", 0, c_if(1), 3);
        cyc("bt_id", 1, c_id(), 3);
        cyc("bt_ex", 2, c_ex(1, 0, 1, 1, 1), 3);
        branch_taken = 1'b0;
        cyc("bn_if", 0, c_if(1), 4);
        cyc("bn_id", 1, c_id(), 4);
        cyc("bn_ex", 2, c_ex(1, 0, 1, 1, 0), 4);

        opcode = OP_JAL;
        cyc("jal_if", 0, c_if(1), 5);
        cyc("jal_id", 1, c_id(), 5);
        cyc("jal_ex", 2, c_ex(0, 0, 0, 0, 1), 5);
        cyc("jal_wb", 4, c_wb(2, 1), 5);

        opcode = OP_JALR;
        cyc("jalr_if", 0, c_if(1), 6);
        cyc("jalr_id", 1, c_id(), 6);
        cyc("jalr_ex", 2, c_ex(1, 2, 0, 0, 2), 6);
        cyc("jalr_wb", 4, c_wb(2, 2), 6);

        opcode = OP_ARITH_IMM;
        cyc("ai_if", 0, c_if(1), 7);
        cyc("ai_id", 1, c_id(), 7);
        cyc("ai_ex", 2, c_ex(1, 2, 2, 0, 0), 7);
        cyc("ai_wb", 4, c_wb(0, 0), 7);

        opcode = 7'h7F;
        cyc("unk_if", 0, c_if(1), 8);
        cyc("unk_id", 1, c_id(), 8);
        cyc("unk_ex", 2, c_ex(0, 0, 0, 1, 0), 8);

        opcode = OP_ECALL; x17 = 32'd5;
        cyc("ec5_if", 0, c_if(1), 8);
        cyc("ec5_id", 1, mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0), 8);

        opcode = OP_ARITH; mem_ready = 1'b0;
        cyc("if_stall", 0, c_if(0), 9);
        cyc("if_stall", 0, c_if(0), 9);
        mem_ready = 1'b1;
        cyc("st_if2", 0, c_if(1), 9);
        cyc("st_id2", 1, c_id(), 9);
        cyc("st_ex2", 2, c_ex(1, 0, 2, 0, 0), 9);
        cyc("st_wb2", 4, c_wb(0, 0), 9);

        opcode = OP_LOAD;
        cyc("rm_if", 0, c_if(1), 10);
        cyc("rm_id", 1, c_id(), 10);
        cyc("rm_ex", 2, c_ex(1, 2, 0, 0, 0), 10);
        mem_ready = 1'b0;
        cyc("rm_wait", 3, c_mem(1, 0, 0), 10);
        rst_m = 1'b0;
        cyc("rm_rstcyc", 3, c_mem(1, 0, 0), 10);
        rst_m = 1'b1;
        cyc("rm_after", 0, c_if(0), 0);
        mem_ready = 1'b1;

        opcode = OP_ARITH;
        cyc("pre_if", 0, c_if(1), 0);
        cyc("pre_id", 1, c_id(), 0);
        cyc("pre_ex", 2, c_ex(1, 0, 2, 0, 0), 0);
        cyc("pre_wb", 4, c_wb(0, 0), 0);
        opcode = OP_ECALL; x17 = 32'd10;
        cyc("h_if", 0, c_if(1), 1);
        cyc("h_id", 1, c_id(), 1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'(i % 2);
            cyc("halt_hold", 5, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        end
        mem_ready = 1'b1;
        rst_m = 1'b0;
        cyc("halt_rst", 5, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        rst_m = 1'b1;
        cyc("halt_out", 0, c_if(1), 0);

        // XLEN=4 instance: 17 branches, counter must wrap through 0.
        rst_m = 1'b0; sel = 1; rst_4 = 1'b1;
        opcode = OP_BRANCH; branch_taken = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cyc("w4_if", 0, c_if(1), i % 16);
            cyc("w4_id", 1, c_id(), i % 16);
            cyc("w4_ex", 2, c_ex(1, 0, 1, 1, 1), i % 16);
        end
        cyc("w4_end", 0, c_if(1), 1);

        // MEM_WAIT=0 instance ignores mem_ready=0.
        rst_4 = 1'b0; sel = 2; rst_nw = 1'b1;
        opcode = OP_LOAD; mem_ready = 1'b0;
        cyc("nw_if", 0, c_if(1), 0);
        cyc("nw_id", 1, c_id(), 0);
        cyc("nw_ex", 2, c_ex(1, 2, 0, 0, 0), 0);
        cyc("nw_mem", 3, c_mem(1, 0, 0), 0);
        cyc("nw_wb", 4, c_wb(1, 0), 0);
        cyc("nw_end", 0, c_if(1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
